// File: rtl/cvsd_pkg.sv
// Shared definitions for the multi-channel CVSD encoder: bank geometry,
// per-channel state record, reset defaults and saturating helpers.
package cvsd_pkg;

  localparam int W   = 8;   // sample / predictor width
  localparam int SW  = 8;   // step register width
  localparam int RCW = 4;   // run counter width, holds RUN up to 8

  localparam logic [W-1:0] XP_INIT       = W'(1 << (W - 1));
  localparam int           STEP_INIT_DEF = 10;

  typedef struct packed {
    logic [W-1:0]   xp;
    logic [SW-1:0]  step;
    logic           last_bit;
    logic [RCW-1:0] run_cnt;
  } chan_state_t;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Predictor arithmetic is done wide; this folds it back into W bits.
  function automatic logic [W-1:0] sat_xp(input int v);
    return W'(clamp(v, 0, (1 << W) - 1));
  endfunction

endpackage

// File: rtl/cvsd_chan_update.sv
// Combinational CVSD step for one channel: (state, x) -> (next state, bit, flag).
module cvsd_chan_update
  import cvsd_pkg::*;
#(
  parameter int RUN        = 3,
  parameter int BETA_NUM   = 245,
  parameter int BETA_SHIFT = 8,
  parameter int DELTA      = 1,
  parameter int STEP_MIN   = 1,
  parameter int STEP_MAX   = 64
) (
  input  chan_state_t  cur,
  input  logic [W-1:0] x,
  output chan_state_t  nxt,
  output logic         enc_bit,
  output logic         flag
);

  localparam logic [RCW-1:0] RUN_L = RCW'(RUN);

  logic [RCW-1:0] run_new;
  int             xp_raw;
  int             step_raw;

  always_comb begin
    enc_bit = (cur.xp <= x);

    if (enc_bit == cur.last_bit && cur.run_cnt != '0)
      run_new = (cur.run_cnt >= RUN_L) ? RUN_L : cur.run_cnt + 1'b1;
    else
      run_new = RCW'(1);
    flag = (run_new >= RUN_L);

    // The old step drives the predictor move; the new step only affects later beats.
    xp_raw   = enc_bit ? int'(cur.xp) + int'(cur.step) : int'(cur.xp) - int'(cur.step);
    step_raw = ((int'(cur.step) * BETA_NUM) >> BETA_SHIFT) + (flag ? DELTA : 0);

    nxt.xp       = sat_xp(xp_raw);
    nxt.step     = SW'(clamp(step_raw, STEP_MIN, STEP_MAX));
    nxt.last_bit = enc_bit;
    nxt.run_cnt  = run_new;
  end

endmodule

// File: rtl/cvsd_enc_mc.sv
// Time-multiplexed CVSD encoder: per-channel state bank, per-channel clear,
// and a registered result beat one cycle after each accepted sample.
module cvsd_enc_mc
  import cvsd_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CW         = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int RUN        = 3,
  parameter int BETA_NUM   = 245,
  parameter int BETA_SHIFT = 8,
  parameter int DELTA      = 1,
  parameter int STEP_INIT  = STEP_INIT_DEF,
  parameter int STEP_MIN   = 1,
  parameter int STEP_MAX   = 64
) (
  input  logic          clk_10k,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_ch,
  input  logic [W-1:0]  x,
  input  logic          clr,
  input  logic [CW-1:0] clr_ch,
  output logic          out_valid,
  output logic          out_bit,
  output logic [CW-1:0] out_ch,
  output logic          out_flag,
  output logic [W-1:0]  out_xp,
  output logic [SW-1:0] out_step
);

  // Handshake: no backpressure. A beat is accepted on any edge where in_valid=1,
  // in_ch is in range and no clear targets the same channel; its result appears
  // as a single-cycle out_valid pulse on the next cycle, other out_* hold otherwise.

  localparam chan_state_t RST_STATE = '{
    xp:       XP_INIT,
    step:     SW'(STEP_INIT),
    last_bit: 1'b0,
    run_cnt:  '0
  };

  chan_state_t bank [NCH];
  chan_state_t cur;
  chan_state_t nxt;
  logic        enc_bit;
  logic        flag;
  logic        ch_ok;
  logic        clr_ok;
  logic        beat_ok;

  always_comb begin
    ch_ok   = ({1'b0, in_ch} < (CW + 1)'(NCH));
    clr_ok  = clr && ({1'b0, clr_ch} < (CW + 1)'(NCH));
    beat_ok = in_valid && ch_ok && !(clr_ok && (clr_ch == in_ch));
    cur     = ch_ok ? bank[in_ch] : RST_STATE;
  end

  cvsd_chan_update #(
    .RUN        (RUN),
    .BETA_NUM   (BETA_NUM),
    .BETA_SHIFT (BETA_SHIFT),
    .DELTA      (DELTA),
    .STEP_MIN   (STEP_MIN),
    .STEP_MAX   (STEP_MAX)
  ) u_update (
    .cur     (cur),
    .x       (x),
    .nxt     (nxt),
    .enc_bit (enc_bit),
    .flag    (flag)
  );

  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) bank[i] <= RST_STATE;
    end else begin
      if (beat_ok) bank[in_ch] <= nxt;
      if (clr_ok) bank[clr_ch] <= RST_STATE;
    end
  end

  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_ch    <= '0;
      out_flag  <= 1'b0;
      out_xp    <= '0;
      out_step  <= '0;
    end else begin
      out_valid <= beat_ok;
      if (beat_ok) begin
        out_bit  <= enc_bit;
        out_ch   <= in_ch;
        out_flag <= flag;
        out_xp   <= nxt.xp;
        out_step <= nxt.step;
      end
    end
  end

endmodule

// File: tb/tb_cvsd_enc_mc.sv
// Bench for cvsd_enc_mc: two instances (default, and NCH=3 with DELTA=20),
// a reference model feeding expected queues, and a negedge monitor.
module tb_cvsd_enc_mc;

  logic       clk_10k = 1'b0;
  logic       rst_n   = 1'b0;
  logic       in_valid [2];
  logic [1:0] in_ch    [2];
  logic [7:0] x        [2];
  logic       clr      [2];
  logic [1:0] clr_ch   [2];
  logic       out_valid[2];
  logic       out_bit  [2];
  logic [1:0] out_ch   [2];
  logic       out_flag [2];
  logic [7:0] out_xp   [2];
  logic [7:0] out_step [2];

  int total = 0;
  int bad   = 0;

  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];

  // Reference model state and per-instance settings.
  int m_xp  [2][4];
  int m_step[2][4];
  int m_last[2][4];
  int m_run [2][4];
  int delta_p[2] = '{1, 20};
  int nch_p  [2] = '{4, 3};

  always #5 clk_10k = ~clk_10k;

  cvsd_enc_mc dut0 (
    .clk_10k(clk_10k), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ch(in_ch[0]), .x(x[0]),
    .clr(clr[0]), .clr_ch(clr_ch[0]),
    .out_valid(out_valid[0]), .out_bit(out_bit[0]), .out_ch(out_ch[0]),
    .out_flag(out_flag[0]), .out_xp(out_xp[0]), .out_step(out_step[0])
  );

  cvsd_enc_mc #(.NCH(3), .DELTA(20)) dut1 (
    .clk_10k(clk_10k), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ch(in_ch[1]), .x(x[1]),
    .clr(clr[1]), .clr_ch(clr_ch[1]),
    .out_valid(out_valid[1]), .out_bit(out_bit[1]), .out_ch(out_ch[1]),
    .out_flag(out_flag[1]), .out_xp(out_xp[1]), .out_step(out_step[1])
  );

  function automatic void model_clear(input int i, input int ch);
    m_xp[i][ch]   = 128;
    m_step[i][ch] = 10;
    m_last[i][ch] = 0;
    m_run[i][ch]  = 0;
  endfunction

  function automatic void model_reset_all();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) model_clear(i, c);
  endfunction

  function automatic logic [19:0] model_beat(input int i, input int ch, input int xv);
    int b, r, f, xn, sn;
    b = (m_xp[i][ch] <= xv) ? 1 : 0;
    if (b == m_last[i][ch] && m_run[i][ch] > 0) r = (m_run[i][ch] + 1 > 3) ? 3 : m_run[i][ch] + 1;
    else r = 1;
    f  = (r >= 3) ? 1 : 0;
    xn = b ? m_xp[i][ch] + m_step[i][ch] : m_xp[i][ch] - m_step[i][ch];
    if (xn > 255) xn = 255;
    if (xn < 0) xn = 0;
    sn = (m_step[i][ch] * 245) / 256 + (f ? delta_p[i] : 0);
    if (sn < 1) sn = 1;
    if (sn > 64) sn = 64;
    m_xp[i][ch] = xn; m_step[i][ch] = sn; m_last[i][ch] = b; m_run[i][ch] = r;
    return {2'(ch), 1'(b), 1'(f), 8'(xn), 8'(sn)};
  endfunction

  // One clock of stimulus on one instance; the model decides what should emerge.
  task automatic drive(input int i, input bit v, input int ch, input int xv,
                       input bit c, input int cch);
    bit ok;
    logic [19:0] e;
    in_valid[i] = v; in_ch[i] = 2'(ch); x[i] = 8'(xv);
    clr[i] = c; clr_ch[i] = 2'(cch);
    ok = v && (ch < nch_p[i]) && !(c && cch < nch_p[i] && cch == ch);
    if (ok) begin
      e = model_beat(i, ch, xv);
      if (i == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
    if (c && cch < nch_p[i]) model_clear(i, cch);
    @(posedge clk_10k);
    #1;
    in_valid[i] = 1'b0;
    clr[i] = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard monitor.
  logic [19:0] got;
  logic [19:0] expv;
  always @(negedge clk_10k) begin
    for (int i = 0; i < 2; i++) begin
      if (out_valid[i]) begin
        got = {out_ch[i], out_bit[i], out_flag[i], out_xp[i], out_step[i]};
        total++;
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
          bad++;
          $display("FAIL unexpected_beat inst=%0d got=%h required=none", i, got);
        end else begin
          if (i == 0) expv = exp_q0.pop_front();
          else expv = exp_q1.pop_front();
          if (got !== expv) begin
            bad++;
            $display("FAIL beat inst=%0d got ch=%0d bit=%0d flag=%0d xp=%0d step=%0d required ch=%0d bit=%0d flag=%0d xp=%0d step=%0d",
                     i, got[19:18], got[17], got[16], got[15:8], got[7:0],
                     expv[19:18], expv[17], expv[16], expv[15:8], expv[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit v, c;
    int ch, xv, cch;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 0; in_ch[i] = 0; x[i] = 0; clr[i] = 0; clr_ch[i] = 0;
    end
    model_reset_all();

    // Reset values.
    #22;
    for (int i = 0; i < 2; i++) begin
      check("rst_valid", int'(out_valid[i]), 0);
      check("rst_xp", int'(out_xp[i]), 0);
      check("rst_step", int'(out_step[i]), 0);
    end
    rst_n = 1'b1;

    // Steady rising input on a fresh channel.
    drive(0, 1, 0, 200, 0, 0);
    check("s1_b1_xp", int'(out_xp[0]), 138);
    check("s1_b1_step", int'(out_step[0]), 9);
    drive(0, 1, 0, 200, 0, 0);
    drive(0, 1, 0, 200, 0, 0);
    check("s1_b3_xp", int'(out_xp[0]), 155);
    check("s1_b3_step", int'(out_step[0]), 8);
    check("s1_b3_flag", int'(out_flag[0]), 1);

    // Interleaved channels on the second instance.
    drive(1, 1, 0, 255, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    check("s2_ch1_xp", int'(out_xp[1]), 118);
    check("s2_ch1_bit", int'(out_bit[1]), 0);
    drive(1, 1, 0, 255, 0, 0);
    check("s2_ch0_xp", int'(out_xp[1]), 147);
    drive(1, 1, 1, 0, 0, 0);
    check("s2_ch1_xp2", int'(out_xp[1]), 109);

    // Large DELTA drives step into its upper clamp and xp into saturation.
    for (int k = 0; k < 12; k++) drive(1, 1, 2, 255, 0, 0);
    check("s3_step_max", int'(out_step[1]), 64);
    check("s3_xp_sat", int'(out_xp[1]), 255);
    check("s3_bit", int'(out_bit[1]), 1);

    // Alternating input decays step to its lower clamp.
    for (int k = 0; k < 30; k++) drive(0, 1, 2, (k % 2) ? 255 : 0, 0, 0);
    check("s4_step_min", int'(out_step[0]), 1);
    check("s4_flag", int'(out_flag[0]), 0);

    // Clear collisions.
    drive(0, 1, 1, 90, 0, 0);
    drive(0, 1, 1, 50, 1, 1);
    check("s5_drop", int'(out_valid[0]), 0);
    drive(0, 1, 0, 77, 1, 1);
    check("s5_other_valid", int'(out_valid[0]), 1);
    check("s5_other_ch", int'(out_ch[0]), 0);
    drive(0, 1, 1, 200, 0, 0);
    check("s5_cleared_xp", int'(out_xp[0]), 138);

    // Out-of-range channel on the 3-channel instance.
    drive(1, 1, 3, 100, 1, 3);
    check("oor_drop", int'(out_valid[1]), 0);

    // Random traffic on both instances.
    for (int k = 0; k < 300; k++) begin
      fork
        begin
          automatic bit v0 = ($urandom_range(0, 3) != 0);
          automatic int x0 = ($urandom_range(0, 4) == 0) ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255);
          drive(0, v0, $urandom_range(0, 3), x0, $urandom_range(0, 9) == 0, $urandom_range(0, 3));
        end
        begin
          automatic bit v1 = ($urandom_range(0, 3) != 0);
          automatic int x1 = ($urandom_range(0, 4) == 0) ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255);
          drive(1, v1, $urandom_range(0, 3), x1, $urandom_range(0, 9) == 0, $urandom_range(0, 3));
        end
      join
    end

    // Asynchronous reset in the middle of a burst.
    drive(0, 1, 0, 200, 0, 0);
    drive(0, 1, 0, 10, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_valid", int'(out_valid[0]), 0);
    check("s6_xp", int'(out_xp[0]), 0);
    check("s6_step", int'(out_step[0]), 0);
    exp_q0.delete();
    exp_q1.delete();
    model_reset_all();
    #4;
    rst_n = 1'b1;
    drive(0, 1, 0, 200, 0, 0);
    check("s6_after_xp", int'(out_xp[0]), 138);
    check("s6_after_step", int'(out_step[0]), 9);
    check("s6_after_bit", int'(out_bit[0]), 1);

    repeat (3) @(posedge clk_10k);
    #1;
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
